defuzz_centroid: RTL and testbench
==================================

# defuzz_centroid

Centroid defuzzifier for the fuzzy controller datapath. It accepts a stream of (rule strength, output singleton) pairs: strengths are Q1.15 values produced by the membership/rule stage, and singletons are Q7.0 crisp values. It computes the weighted average sum(mu·s)/sum(mu) with a multi-cycle serial divider and returns one Q7.0 crisp output per stream. It sits between the rule-aggregation stage and the actuator/output register.

## Interface
Parameters:
- MAX_RULES, 8, maximum beats accumulated per stream; sets the accumulator widths (CW = clog2(MAX_RULES+1)).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous and active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat.
- in_mu  in  16  rule strength, Q1.15 unsigned, legal range 0..0x7FFF.
- in_s  in  8  signed Q7.0 singleton.
- in_last  in  1  marks the final beat of a stream.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_y  out  8  signed Q7.0 crisp output.
- out_zero_w  out  1  sum of weights was 0; out_y forced to 0.
- out_ovf  out  1  more than MAX_RULES beats arrived in the stream.

## Operation
- States: ACC, DIV, OUT.
- ACC:
  - in_ready=1. A beat is accepted when in_valid&in_ready.
  - Per accepted beat: sum_w += in_mu (unsigned, 16+CW bits); sum_ws += in_mu·in_s (signed, 24+CW bits); beat_cnt++ (saturating).
  - Beats with beat_cnt ≥ MAX_RULES are accepted but not accumulated, and they set ovf.
- Accepted beat with in_last:
  - The accumulators include that beat.
  - If the resulting sum_w==0: go to OUT with y=0 and zero_w=1.
  - Otherwise go to DIV.
- DIV:
  - Sign-magnitude restoring division of |sum_ws| by sum_w.
  - 8 iterations, i=7..0, one per cycle: if rem ≥ (sum_w<<i), subtract it and set q[i].
  - The quotient fits in 8 bits because |sum_ws| ≤ 128·sum_w.
  - Result is truncated toward zero. If sum_ws<0, y = −q.
  - Clamp to −128..127; the only case needing it is q=128 with a positive sign.
  - in_ready=0.
- OUT:
  - out_valid=1. out_y, out_zero_w and out_ovf are held stable until out_ready.
  - On out_valid&out_ready: clear sum_w, sum_ws, beat_cnt and ovf, then return to ACC.
  - in_ready=0 in OUT; there is no overlap of the next stream with the result.
- A stream with in_last on its first beat is legal (single rule).
- In the source stage in_mu[15] is always 0. If it is set here, the value is still treated as unsigned 16-bit, and the accumulator widths cover it.

## Timing
- Reset values: state=ACC, in_ready=1, out_valid=0, out_y=0, out_zero_w=0, out_ovf=0, all accumulators and counters 0.
- Reset asserted mid-stream or mid-DIV aborts the operation immediately. No partial result is emitted.
- Latency, with the last beat accepted at edge k:
  - Nonzero weight: DIV occupies cycles k+1..k+8, and out_valid rises after edge k+8 (8 DIV cycles).
  - Zero weight: out_valid rises after edge k.
- in_ready is combinational from state only (1 iff ACC). No combinational path from in_valid to in_ready.
- out_valid/out_y are registered. With out_ready held high, the result lasts exactly 1 cycle and in_ready returns the next cycle.
- Back-to-back streams: minimum period is beats + 9 cycles.

## Structure
- The shared fuzzy package holds:
  - Q-format constants: Q15_ONE=16'h7FFF, Y_MIN=−128, Y_MAX=127.
  - The mu/singleton width localparams, shared with the membership evaluator.
  - The state enum encoding.
- One sub-module, defuzz_div_serial: a start/busy/done unsigned restoring divider (8-bit quotient, parameterised numerator/denominator widths). The top keeps the FSM, accumulators, sign handling and clamp.

## Test plan
- Two beats (0x7FFF, 10), (0x7FFF, 20, last) → out_y=15, zero_w=0, out_valid 9 cycles after the last beat.
- Two beats (0x4000, −100), (0x4000, −51, last) → out_y=−75 (truncation toward zero of −75.5).
- Single beat (0x0001, −128, last) → out_y=−128. Single beat (0x7FFF, 127, last) → out_y=127.
- Three beats, all mu=0 → out_y=0, zero_w=1, out_valid 1 cycle after the last beat.
- Hold out_ready low 5 cycles during OUT → out_y and flags stable, in_ready=0, in_valid beats not accepted. Then release → in_ready=1 the next cycle, and the next stream's accumulation starts from 0.
- MAX_RULES+2 beats of (0x7FFF, 50) → out_y=50, ovf=1. Separately, assert rst during DIV cycle 4 → outputs at reset values and no out_valid pulse. A following stream then yields the correct result.

Source files
------------

// File: rtl/defuzz_centroid_pkg.sv
// Shared fuzzy-datapath package.
// Holds the Q-format constants, the mu/singleton widths shared with the
// membership evaluator, the defuzzifier state encoding, and the
// sign/clamp helper used when a quotient becomes a crisp output.
package defuzz_centroid_pkg;

  // Rule strength (Q1.15 unsigned) and singleton (signed Q7.0) widths
  localparam int MU_W = 16;
  localparam int S_W  = 8;
  localparam int Y_W  = 8;
  localparam int Q_W  = 8;   // divider quotient width

  localparam logic [MU_W-1:0] Q15_ONE = 16'h7FFF;
  localparam int Y_MIN = -128;
  localparam int Y_MAX = 127;

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_DIV = 2'd1,
    ST_OUT = 2'd2
  } dfz_state_e;

  // Apply the stream sign to an unsigned quotient magnitude and clamp the
  // result into the signed Q7.0 output range. Only +128 actually needs it.
  function automatic logic [Y_W-1:0] apply_sign_clamp(input logic neg,
                                                      input logic [Q_W-1:0] mag);
    logic signed [Q_W+1:0] v;
    v = $signed({2'b00, mag});
    if (neg) v = -v;
    if (v > $signed((Q_W+2)'(Y_MAX)))      v = $signed((Q_W+2)'(Y_MAX));
    else if (v < $signed((Q_W+2)'(Y_MIN))) v = $signed((Q_W+2)'(Y_MIN));
    return v[Y_W-1:0];
  endfunction

endpackage

// File: rtl/defuzz_centroid_div.sv
// defuzz_div_serial: unsigned restoring divider producing an 8-bit quotient,
// one quotient bit per cycle from the MSB down.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start          load num/den and begin (ignored fields otherwise)
//   num, den       unsigned numerator / denominator
//   busy           iteration in progress
//   done           high in the cycle of the final iteration (bit 0)
//   quot           quotient including the current iteration's bit; complete
//                  when done is high
module defuzz_div_serial
  import defuzz_centroid_pkg::*;
#(
  parameter int NUM_W = 28,
  parameter int DEN_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quot
);

  localparam int IDX_W = $clog2(Q_W);
  // Comparison width must hold both the remainder and den << (Q_W-1)
  localparam int CMP_W = (NUM_W > DEN_W + Q_W) ? NUM_W : DEN_W + Q_W;

  logic [NUM_W-1:0] rem_q, rem_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [Q_W-1:0]   quot_q, quot_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;

  logic [CMP_W-1:0] shifted;
  logic             take;
  logic [NUM_W-1:0] rem_step;
  logic [Q_W-1:0]   quot_step;

  always_comb begin
    shifted   = CMP_W'(den_q) << idx_q;
    take      = CMP_W'(rem_q) >= shifted;
    // shifted never exceeds rem_q when take is set, so truncation is safe
    rem_step  = take ? (rem_q - NUM_W'(shifted)) : rem_q;
    quot_step = quot_q | (take ? (Q_W'(1) << idx_q) : '0);
  end

  always_comb begin
    rem_d  = rem_q;
    den_d  = den_q;
    quot_d = quot_q;
    idx_d  = idx_q;
    busy_d = busy_q;
    if (start) begin
      rem_d  = num;
      den_d  = den;
      quot_d = '0;
      idx_d  = IDX_W'(Q_W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d  = rem_step;
      quot_d = quot_step;
      idx_d  = idx_q - 1'b1;
      if (idx_q == '0) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      den_q  <= '0;
      quot_q <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      den_q  <= den_d;
      quot_q <= quot_d;
      idx_q  <= idx_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (idx_q == '0);
  assign quot = quot_step;

endmodule

// File: rtl/defuzz_centroid.sv
// defuzz_centroid: centroid defuzzifier. Accumulates (mu, s) beats of one
// stream, then returns sum(mu*s)/sum(mu) truncated toward zero as signed Q7.0.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   in_valid/in_ready               input beat handshake (ready iff ACC)
//   in_mu, in_s, in_last            strength, singleton, end-of-stream
//   out_valid/out_ready             result handshake (held until accepted)
//   out_y, out_zero_w, out_ovf      crisp output, zero-weight and overflow flags
module defuzz_centroid
  import defuzz_centroid_pkg::*;
#(
  parameter int MAX_RULES = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [MU_W-1:0] in_mu,
  input  logic [S_W-1:0]  in_s,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [Y_W-1:0]  out_y,
  output logic            out_zero_w,
  output logic            out_ovf
);

  localparam int CW    = $clog2(MAX_RULES + 1);
  localparam int SW_W  = MU_W + CW;        // sum of weights
  localparam int SWS_W = MU_W + S_W + CW;  // signed weighted sum

  dfz_state_e              state_q, state_d;
  logic [SW_W-1:0]         sum_w_q, sum_w_d;
  logic signed [SWS_W-1:0] sum_ws_q, sum_ws_d;
  logic [CW-1:0]           beat_cnt_q, beat_cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    neg_q, neg_d;
  logic [Y_W-1:0]          out_y_q, out_y_d;
  logic                    out_zero_w_q, out_zero_w_d;
  logic                    out_ovf_q, out_ovf_d;

  logic                      accept;
  logic                      acc_en;
  logic signed [MU_W+S_W:0]  prod;
  logic [SW_W-1:0]           acc_w;
  logic signed [SWS_W-1:0]   acc_ws;
  logic [SWS_W-1:0]          mag;

  logic           div_start;
  logic           div_busy;
  logic           div_done;
  logic [Q_W-1:0] div_quot;

  assign accept = (state_q == ST_ACC) && in_valid;
  // Beats past MAX_RULES are swallowed without touching the sums
  assign acc_en = beat_cnt_q < CW'(MAX_RULES);
  // mu is zero-extended so a stray bit 15 still counts as a positive weight
  assign prod   = $signed({1'b0, in_mu}) * $signed(in_s);
  assign acc_w  = acc_en ? (sum_w_q + SW_W'(in_mu)) : sum_w_q;
  assign acc_ws = acc_en ? (sum_ws_q + SWS_W'(prod)) : sum_ws_q;
  assign mag    = acc_ws[SWS_W-1] ? SWS_W'(-acc_ws) : SWS_W'(acc_ws);

  always_comb begin
    state_d      = state_q;
    sum_w_d      = sum_w_q;
    sum_ws_d     = sum_ws_q;
    beat_cnt_d   = beat_cnt_q;
    ovf_d        = ovf_q;
    neg_d        = neg_q;
    out_y_d      = out_y_q;
    out_zero_w_d = out_zero_w_q;
    out_ovf_d    = out_ovf_q;
    div_start    = 1'b0;

    case (state_q)
      ST_ACC: begin
        if (accept) begin
          sum_w_d  = acc_w;
          sum_ws_d = acc_ws;
          if (acc_en) beat_cnt_d = beat_cnt_q + 1'b1;
          else        ovf_d      = 1'b1;
          if (in_last) begin
            if (acc_w == '0) begin
              state_d      = ST_OUT;
              out_y_d      = '0;
              out_zero_w_d = 1'b1;
              out_ovf_d    = ovf_d;
            end else begin
              // Divider loads the sums including this last beat
              state_d   = ST_DIV;
              div_start = 1'b1;
              neg_d     = acc_ws[SWS_W-1];
            end
          end
        end
      end
      ST_DIV: begin
        if (div_busy && div_done) begin
          state_d      = ST_OUT;
          out_y_d      = apply_sign_clamp(neg_q, div_quot);
          out_zero_w_d = 1'b0;
          out_ovf_d    = ovf_q;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d    = ST_ACC;
          sum_w_d    = '0;
          sum_ws_d   = '0;
          beat_cnt_d = '0;
          ovf_d      = 1'b0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ACC;
      sum_w_q      <= '0;
      sum_ws_q     <= '0;
      beat_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      neg_q        <= 1'b0;
      out_y_q      <= '0;
      out_zero_w_q <= 1'b0;
      out_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sum_w_q      <= sum_w_d;
      sum_ws_q     <= sum_ws_d;
      beat_cnt_q   <= beat_cnt_d;
      ovf_q        <= ovf_d;
      neg_q        <= neg_d;
      out_y_q      <= out_y_d;
      out_zero_w_q <= out_zero_w_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

  defuzz_div_serial #(
    .NUM_W(SWS_W),
    .DEN_W(SW_W)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .start(div_start),
    .num  (mag),
    .den  (acc_w),
    .busy (div_busy),
    .done (div_done),
    .quot (div_quot)
  );

  assign in_ready   = (state_q == ST_ACC);
  assign out_valid  = (state_q == ST_OUT);
  assign out_y      = out_y_q;
  assign out_zero_w = out_zero_w_q;
  assign out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_defuzz_centroid.sv
module tb_defuzz_centroid;
  import defuzz_centroid_pkg::*;

  localparam int MAX_RULES = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_mu = '0;
  logic [7:0]  in_s = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_y;
  logic        out_zero_w;
  logic        out_ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0]       mu_a [0:15];
  logic signed [7:0] s_a  [0:15];

  defuzz_centroid #(.MAX_RULES(MAX_RULES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mu     (in_mu),
    .in_s      (in_s),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_zero_w(out_zero_w),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: weighted average over the first MAX_RULES beats, truncated
  // toward zero by integer division, clamped to the Q7.0 range.
  function automatic void model(input int n, output logic [7:0] y,
                                output logic zw, output logic ov);
    longint sw = 0;
    longint sws = 0;
    longint q;
    for (int i = 0; i < n; i++) begin
      if (i < MAX_RULES) begin
        sw  += longint'(mu_a[i]);
        sws += longint'(mu_a[i]) * longint'(s_a[i]);
      end
    end
    ov = (n > MAX_RULES);
    if (sw == 0) begin
      y = 8'd0; zw = 1'b1;
    end else begin
      q = sws / sw;
      if (q > Y_MAX) q = Y_MAX;
      if (q < Y_MIN) q = Y_MIN;
      y = 8'(q); zw = 1'b0;
    end
  endfunction

  // Called at #1 after an edge with the block in ACC; returns #1 after the
  // edge that accepted the last beat.
  task automatic drive_stream(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_mu    = mu_a[i];
      in_s     = s_a[i];
      in_last  = (i == n - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, out_y, out_zero_w, out_ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b y=%0d zw=%b ovf=%b want rdy=1 vld=0 y=0 zw=0 ovf=0",
               in_ready, out_valid, $signed(out_y), out_zero_w, out_ovf);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int lat;
    int n;
    logic [7:0] exp_y;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin n = 2; mu_a[0] = Q15_ONE; s_a[0] = 8'sd10;  mu_a[1] = Q15_ONE; s_a[1] = 8'sd20;  exp_y = 8'd15; end
        1: begin n = 2; mu_a[0] = 16'h4000; s_a[0] = -8'sd100; mu_a[1] = 16'h4000; s_a[1] = -8'sd51; exp_y = 8'hB5; end
        2: begin n = 1; mu_a[0] = 16'h0001; s_a[0] = -8'sd128; exp_y = 8'h80; end
        default: begin n = 1; mu_a[0] = Q15_ONE; s_a[0] = 8'sd127; exp_y = 8'd127; end
      endcase
      drive_stream(n);
      wait_out(lat);
      $display("directed %0d: n=%0d y=%0d zw=%b ovf=%b lat=%0d", c, n, $signed(out_y), out_zero_w, out_ovf, lat);
      checks++;
      if (out_y !== exp_y) begin
        errors++;
        $display("FAIL directed_y[%0d]: got %0d want %0d", c, $signed(out_y), $signed(exp_y));
      end
      checks++;
      if ({out_zero_w, out_ovf} !== 2'b00) begin
        errors++;
        $display("FAIL directed_flags[%0d]: got zw=%b ovf=%b want 0 0", c, out_zero_w, out_ovf);
      end
      checks++;
      if (lat != 8) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d want 8", c, lat);
      end
      release_out();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++;
        $display("FAIL directed_release[%0d]: got vld=%b rdy=%b want 0 1", c, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_zero_w();
    int lat;
    for (int i = 0; i < 3; i++) begin
      mu_a[i] = 16'h0000;
      s_a[i]  = 8'($urandom);
    end
    drive_stream(3);
    wait_out(lat);
    $display("zero_w: y=%0d zw=%b ovf=%b lat=%0d", $signed(out_y), out_zero_w, out_ovf, lat);
    checks++;
    if ({out_y, out_zero_w, out_ovf} !== {8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL zero_w_result: got y=%0d zw=%b ovf=%b want y=0 zw=1 ovf=0", $signed(out_y), out_zero_w, out_ovf);
    end
    checks++;
    if (lat != 0) begin
      errors++;
      $display("FAIL zero_w_latency: got %0d want 0", lat);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    // 8192*40 - 24576*20 = -163840 over 32768 -> -5
    mu_a[0] = 16'h2000; s_a[0] = 8'sd40;
    mu_a[1] = 16'h6000; s_a[1] = -8'sd20;
    drive_stream(2);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_mu    = 16'($urandom);
      in_s     = 8'($urandom);
      in_last  = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, out_y, out_zero_w, out_ovf} !== {1'b1, 1'b0, 8'hFB, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL hold[%0d]: got vld=%b rdy=%b y=%0d zw=%b ovf=%b want vld=1 rdy=0 y=-5 zw=0 ovf=0",
                 i, out_valid, in_ready, $signed(out_y), out_zero_w, out_ovf);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    $display("backpressure: held y=%0d for 5 cycles", $signed(out_y));
    release_out();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: got rdy=%b want 1", in_ready);
    end
    mu_a[0] = Q15_ONE; s_a[0] = 8'sd10;
    mu_a[1] = Q15_ONE; s_a[1] = 8'sd20;
    drive_stream(2);
    wait_out(lat);
    $display("after hold: y=%0d lat=%0d", $signed(out_y), lat);
    checks++;
    if (out_y !== 8'd15 || lat != 8) begin
      errors++;
      $display("FAIL fresh_accum: got y=%0d lat=%0d want y=15 lat=8", $signed(out_y), lat);
    end
    release_out();
  endtask

  task automatic test_ovf();
    int lat;
    int n;
    logic [7:0] exp_y;
    logic exp_ovf;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin n = MAX_RULES + 2; exp_y = 8'd50; exp_ovf = 1'b1;
                 for (int i = 0; i < n; i++) begin mu_a[i] = Q15_ONE; s_a[i] = 8'sd50; end end
        1: begin n = MAX_RULES + 2; exp_y = 8'd50; exp_ovf = 1'b1;
                 for (int i = 0; i < n; i++) begin mu_a[i] = Q15_ONE; s_a[i] = (i < MAX_RULES) ? 8'sd50 : -8'sd100; end end
        default: begin n = MAX_RULES; exp_y = 8'hE2; exp_ovf = 1'b0;
                 for (int i = 0; i < n; i++) begin mu_a[i] = 16'h1234; s_a[i] = -8'sd30; end end
      endcase
      drive_stream(n);
      wait_out(lat);
      $display("ovf %0d: n=%0d y=%0d ovf=%b lat=%0d", c, n, $signed(out_y), out_ovf, lat);
      checks++;
      if (out_y !== exp_y || out_ovf !== exp_ovf || out_zero_w !== 1'b0) begin
        errors++;
        $display("FAIL ovf[%0d]: got y=%0d ovf=%b zw=%b want y=%0d ovf=%b zw=0",
                 c, $signed(out_y), out_ovf, out_zero_w, $signed(exp_y), exp_ovf);
      end
      release_out();
    end
  endtask

  task automatic test_reset_mid_div();
    int lat;
    bit seen;
    mu_a[0] = Q15_ONE; s_a[0] = 8'sd60;
    mu_a[1] = 16'h1000; s_a[1] = -8'sd10;
    drive_stream(2);
    // Last beat at edge k; DIV cycle 4 begins after edge k+3
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, out_y, out_zero_w, out_ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_div_reset: got rdy=%b vld=%b y=%0d zw=%b ovf=%b want rdy=1 vld=0 y=0 zw=0 ovf=0",
               in_ready, out_valid, $signed(out_y), out_zero_w, out_ovf);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_div_no_pulse: got out_valid pulse=1 want 0");
    end
    mu_a[0] = 16'h4000; s_a[0] = -8'sd100;
    mu_a[1] = 16'h4000; s_a[1] = -8'sd51;
    drive_stream(2);
    wait_out(lat);
    $display("after reset: y=%0d lat=%0d", $signed(out_y), lat);
    checks++;
    if (out_y !== 8'hB5 || lat != 8) begin
      errors++;
      $display("FAIL post_reset_stream: got y=%0d lat=%0d want y=-75 lat=8", $signed(out_y), lat);
    end
    release_out();
  endtask

  task automatic test_random();
    int lat;
    int n;
    logic [7:0] exp_y;
    logic exp_zw;
    logic exp_ovf;
    bit all_zero;
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, 11);
      all_zero = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < n; i++) begin
        mu_a[i] = (all_zero || $urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
        s_a[i]  = 8'($urandom);
      end
      model(n, exp_y, exp_zw, exp_ovf);
      drive_stream(n);
      wait_out(lat);
      $display("random %0d: n=%0d y=%0d zw=%b ovf=%b lat=%0d", t, n, $signed(out_y), out_zero_w, out_ovf, lat);
      checks++;
      if (out_y !== exp_y || out_zero_w !== exp_zw || out_ovf !== exp_ovf) begin
        errors++;
        $display("FAIL random[%0d]: got y=%0d zw=%b ovf=%b want y=%0d zw=%b ovf=%b",
                 t, $signed(out_y), out_zero_w, out_ovf, $signed(exp_y), exp_zw, exp_ovf);
      end
      checks++;
      if (lat != (exp_zw ? 0 : 8)) begin
        errors++;
        $display("FAIL random_latency[%0d]: got %0d want %0d", t, lat, exp_zw ? 0 : 8);
      end
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int n;
    int start_cyc;
    logic [7:0] exp_y;
    logic exp_zw;
    logic exp_ovf;
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        mu_a[i] = 16'($urandom_range(1, 32767));
        s_a[i]  = 8'($urandom);
      end
      model(n, exp_y, exp_zw, exp_ovf);
      start_cyc = cyc;
      drive_stream(n);
      wait_out(lat);
      checks++;
      if (out_y !== exp_y) begin
        errors++;
        $display("FAIL b2b_y[%0d]: got %0d want %0d", t, $signed(out_y), $signed(exp_y));
      end
      @(posedge clk); #1;
      $display("b2b %0d: n=%0d y=%0d period=%0d", t, n, $signed(exp_y), cyc - start_cyc);
      checks++;
      if ({out_valid, in_ready} !== 2'b01 || (cyc - start_cyc) != n + 9) begin
        errors++;
        $display("FAIL b2b_period[%0d]: got vld=%b rdy=%b period=%0d want vld=0 rdy=1 period=%0d",
                 t, out_valid, in_ready, cyc - start_cyc, n + 9);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_w();
    test_backpressure();
    test_ovf();
    test_reset_mid_div();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
